// File: rtl/fetch_stage.sv
// Instruction fetch front end: issues I-cache requests under a credit rule, tracks
// in-order responses (discarding those killed by a flush) and buffers them for decode.
package fetch_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] predict_address;
        logic        predict_taken;
    } branchpredict_sbe_t;
endpackage

module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned FETCH_FIFO_DEPTH = 4,
    parameter int unsigned MAX_OUTSTANDING  = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic [63:0]        fetch_address_i,
    input  logic               fetch_valid_i,
    input  branchpredict_sbe_t branch_predict_i,
    output logic               if_ready_o,
    output logic               instr_req_o,
    output logic [63:0]        instr_addr_o,
    input  logic               instr_gnt_i,
    input  logic               instr_rvalid_i,
    input  logic [31:0]        instr_rdata_i,
    output logic               fetch_entry_valid_o,
    output logic [63:0]        fetch_entry_addr_o,
    output logic [31:0]        fetch_entry_rdata_o,
    output branchpredict_sbe_t fetch_entry_bp_o,
    input  logic               fetch_entry_ready_i
);

    localparam int unsigned PTR_W = $clog2(FETCH_FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned PQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef struct packed {
        logic [63:0]        addr;
        branchpredict_sbe_t bp;
    } pend_t;

    typedef struct packed {
        logic [63:0]        addr;
        logic [31:0]        rdata;
        branchpredict_sbe_t bp;
    } entry_t;

    logic [1:0]       inflight_q, inflight_d;
    logic [1:0]       killed_q, killed_d;
    logic [1:0]       live;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W:0]   credit;
    logic [PTR_W-1:0] fifo_wr_q, fifo_rd_q;
    logic [PQ_W-1:0]  pq_wr_q, pq_rd_q;
    logic             gnt_fire, rsp_valid, rsp_discard, rsp_accept, fifo_pop;

    pend_t  pend_mem [MAX_OUTSTANDING];
    entry_t fifo_mem [FETCH_FIFO_DEPTH];

    function automatic logic [PQ_W-1:0] pq_next(input logic [PQ_W-1:0] p);
        return (p == PQ_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request side: live responses plus buffered entries must always fit in the FIFO
    assign live         = inflight_q - killed_q;
    assign credit       = (CNT_W+1)'(live) + (CNT_W+1)'(count_q);
    assign instr_req_o  = rst_ni & fetch_valid_i & ~flush_i
                        & (inflight_q < 2'(MAX_OUTSTANDING))
                        & (credit < (CNT_W+1)'(FETCH_FIFO_DEPTH));
    assign instr_addr_o = {fetch_address_i[63:2], 2'b00};
    assign gnt_fire     = instr_req_o & instr_gnt_i;
    assign if_ready_o   = gnt_fire;

    // Response side: a stray rvalid with nothing in flight is ignored
    assign rsp_valid   = instr_rvalid_i & (inflight_q != 2'd0);
    assign rsp_discard = rsp_valid & (flush_i | (killed_q != 2'd0));
    assign rsp_accept  = rsp_valid & ~rsp_discard;
    assign fifo_pop    = fetch_entry_valid_o & fetch_entry_ready_i & ~flush_i;

    assign inflight_d = inflight_q + {1'b0, gnt_fire} - {1'b0, rsp_valid};
    assign killed_d   = flush_i ? (inflight_q - {1'b0, rsp_valid})
                                : (killed_q - {1'b0, rsp_discard});
    assign count_d    = flush_i ? '0
                                : count_q + CNT_W'(rsp_accept) - CNT_W'(fifo_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= '0;
            killed_q   <= '0;
            count_q    <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            pq_wr_q    <= '0;
            pq_rd_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            killed_q   <= killed_d;
            count_q    <= count_d;
            if (flush_i) begin
                fifo_wr_q <= '0;
                fifo_rd_q <= '0;
                pq_wr_q   <= '0;
                pq_rd_q   <= '0;
            end else begin
                if (rsp_accept) fifo_wr_q <= fifo_wr_q + 1'b1;
                if (fifo_pop)   fifo_rd_q <= fifo_rd_q + 1'b1;
                if (gnt_fire)   pq_wr_q   <= pq_next(pq_wr_q);
                if (rsp_accept) pq_rd_q   <= pq_next(pq_rd_q);
            end
        end
    end

    // Storage stage: payload only, validity lives in the counters above
    always_ff @(posedge clk_i) begin
        if (gnt_fire)
            pend_mem[pq_wr_q] <= '{addr: fetch_address_i, bp: branch_predict_i};
        if (rsp_accept)
            fifo_mem[fifo_wr_q] <= '{addr: pend_mem[pq_rd_q].addr, rdata: instr_rdata_i,
                                     bp: pend_mem[pq_rd_q].bp};
    end

    assign fetch_entry_valid_o = (count_q != '0);
    assign fetch_entry_addr_o  = fifo_mem[fifo_rd_q].addr;
    assign fetch_entry_rdata_o = fifo_mem[fifo_rd_q].rdata;
    assign fetch_entry_bp_o    = fifo_mem[fifo_rd_q].bp;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rsp_accept && count_q == CNT_W'(FETCH_FIFO_DEPTH)));
    a_rvalid_protocol: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(instr_rvalid_i && inflight_q == 2'd0));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, all checked each cycle
// against a queue-based model of the fetch/flush rules.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic               flush_i = 1'b0;
    logic [63:0]        fetch_address_i = '0;
    logic               fetch_valid_i = 1'b0;
    branchpredict_sbe_t branch_predict_i = '0;
    logic               if_ready_o, instr_req_o;
    logic [63:0]        instr_addr_o;
    logic               instr_gnt_i = 1'b0;
    logic               instr_rvalid_i = 1'b0;
    logic [31:0]        instr_rdata_i = '0;
    logic               fetch_entry_valid_o;
    logic [63:0]        fetch_entry_addr_o;
    logic [31:0]        fetch_entry_rdata_o;
    branchpredict_sbe_t fetch_entry_bp_o;
    logic               fetch_entry_ready_i = 1'b0;

    fetch_stage #(.FETCH_FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .fetch_address_i(fetch_address_i), .fetch_valid_i(fetch_valid_i),
        .branch_predict_i(branch_predict_i), .if_ready_o(if_ready_o),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
        .fetch_entry_valid_o(fetch_entry_valid_o), .fetch_entry_addr_o(fetch_entry_addr_o),
        .fetch_entry_rdata_o(fetch_entry_rdata_o), .fetch_entry_bp_o(fetch_entry_bp_o),
        .fetch_entry_ready_i(fetch_entry_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [63:0] addr; branchpredict_sbe_t bp; } pend_t;
    typedef struct { logic [63:0] addr; logic [31:0] data; branchpredict_sbe_t bp; } ent_t;

    pend_t m_pend[$];
    ent_t  m_fifo[$];
    int    m_inflight = 0;
    int    m_killed = 0;
    int    n_cmp = 0;
    int    n_fail = 0;
    int    grants = 0;
    logic  pend_rv = 1'b0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs for the inputs currently driven, advance the model, move to next cycle.
    task automatic tick();
        logic e_req, e_rdy;
        int   live;
        #1;
        if (!rst_ni) begin
            m_pend.delete(); m_fifo.delete(); m_inflight = 0; m_killed = 0;
        end
        live  = m_inflight - m_killed;
        e_req = rst_ni && fetch_valid_i && !flush_i && (m_inflight < MAXO)
                && ((live + m_fifo.size()) < DEPTH);
        e_rdy = e_req && instr_gnt_i;
        check("instr_req", instr_req_o, e_req);
        check("if_ready", if_ready_o, e_rdy);
        if (e_req) check("instr_addr", instr_addr_o, {fetch_address_i[63:2], 2'b00});
        check("entry_valid", fetch_entry_valid_o, m_fifo.size() != 0);
        if (m_fifo.size() != 0) begin
            check("entry_addr", fetch_entry_addr_o, m_fifo[0].addr);
            check("entry_rdata", fetch_entry_rdata_o, m_fifo[0].data);
            check("entry_bp", fetch_entry_bp_o, m_fifo[0].bp);
        end
        if (e_rdy) grants++;
        if (rst_ni) begin
            if (flush_i) begin
                if (instr_rvalid_i && m_inflight > 0) m_inflight--;
                m_killed = m_inflight;
                m_pend.delete();
                m_fifo.delete();
            end else begin
                if (m_fifo.size() != 0 && fetch_entry_ready_i) void'(m_fifo.pop_front());
                if (instr_rvalid_i && m_inflight > 0) begin
                    m_inflight--;
                    if (m_killed > 0) m_killed--;
                    else begin
                        pend_t p;
                        p = m_pend.pop_front();
                        m_fifo.push_back('{p.addr, instr_rdata_i, p.bp});
                    end
                end
                if (e_rdy) begin
                    m_pend.push_back('{fetch_address_i, branch_predict_i});
                    m_inflight++;
                end
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Cache that answers exactly one cycle after each grant.
    task automatic echo_cycles(input int n);
        int g;
        for (int i = 0; i < n; i++) begin
            instr_rvalid_i = pend_rv;
            instr_rdata_i  = $urandom;
            g = grants;
            tick();
            pend_rv = (grants != g);
        end
        instr_rvalid_i = 1'b0;
    endtask

    initial begin
        // Reset state, with a fetch pending to prove instr_req_o is held low
        fetch_valid_i = 1'b1;
        @(negedge clk_i);
        tick(); tick();
        rst_ni = 1'b1;
        fetch_valid_i = 1'b0;
        tick();

        // Single fetch
        fetch_address_i = 64'h8000_0002; fetch_valid_i = 1'b1; instr_gnt_i = 1'b1;
        branch_predict_i = '{valid: 1'b1, predict_address: 64'h1234, predict_taken: 1'b1};
        #1 check("single_addr", instr_addr_o, 64'h8000_0000);
        tick();
        fetch_valid_i = 1'b0; instr_gnt_i = 1'b0;
        tick();
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'hDEAD_BEEF;
        tick();
        instr_rvalid_i = 1'b0;
        #1 check("single_valid", fetch_entry_valid_o, 1'b1);
        check("single_eaddr", fetch_entry_addr_o, 64'h8000_0002);
        check("single_data", fetch_entry_rdata_o, 32'hDEAD_BEEF);
        fetch_entry_ready_i = 1'b1;
        tick();

        // Back-pressure: FIFO fills after exactly DEPTH grants
        fetch_entry_ready_i = 1'b0; fetch_valid_i = 1'b1; instr_gnt_i = 1'b1;
        fetch_address_i = 64'h0000_1000; grants = 0; pend_rv = 1'b0;
        echo_cycles(10);
        check("bp_grants", grants, 4);
        #1 check("bp_req_low", instr_req_o, 1'b0);
        fetch_entry_ready_i = 1'b1;
        tick();
        fetch_entry_ready_i = 1'b0;
        echo_cycles(6);
        check("bp_one_more", grants, 5);
        fetch_valid_i = 1'b0; fetch_entry_ready_i = 1'b1;
        echo_cycles(8);

        // Outstanding cap
        fetch_valid_i = 1'b1; instr_gnt_i = 1'b1; fetch_address_i = 64'h0000_2004; grants = 0;
        tick(); tick();
        #1 check("cap_req_low", instr_req_o, 1'b0);
        tick();
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0000_00A1;
        tick();
        instr_rvalid_i = 1'b0;
        #1 check("cap_resume", instr_req_o, 1'b1);
        tick();
        check("cap_grants", grants, 3);
        fetch_valid_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0000_00A2;
        tick();
        instr_rdata_i = 32'h0000_00A3;
        tick();
        instr_rvalid_i = 1'b0;
        tick(); tick(); tick();

        // Flush with two in flight
        fetch_valid_i = 1'b1; fetch_address_i = 64'h0000_0040;
        tick(); tick();
        fetch_valid_i = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0000_1111;
        tick();
        instr_rdata_i = 32'h0000_2222;
        tick();
        instr_rvalid_i = 1'b0;
        #1 check("flush_killed_gone", fetch_entry_valid_o, 1'b0);
        fetch_valid_i = 1'b1; fetch_address_i = 64'h0000_0100;
        tick();
        fetch_valid_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0000_3333;
        tick();
        instr_rvalid_i = 1'b0;
        #1 check("flush_new_data", fetch_entry_rdata_o, 32'h0000_3333);
        check("flush_new_addr", fetch_entry_addr_o, 64'h0000_0100);
        tick();

        // Flush coinciding with rvalid
        fetch_valid_i = 1'b1; fetch_address_i = 64'h0000_0180;
        tick(); tick();
        fetch_valid_i = 1'b0; flush_i = 1'b1; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0000_AAAA;
        tick();
        flush_i = 1'b0; instr_rvalid_i = 1'b0;
        check("coinc_killed", dut.killed_q, 2'd1);
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0000_BBBB;
        tick();
        instr_rvalid_i = 1'b0;
        #1 check("coinc_discard", fetch_entry_valid_o, 1'b0);
        fetch_valid_i = 1'b1; fetch_address_i = 64'h0000_0200;
        tick();
        fetch_valid_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0000_4444;
        tick();
        instr_rvalid_i = 1'b0;
        #1 check("coinc_accept", fetch_entry_rdata_o, 32'h0000_4444);
        tick();

        // Async reset mid-burst with three entries buffered
        fetch_entry_ready_i = 1'b0; fetch_valid_i = 1'b1; fetch_address_i = 64'h0000_3000;
        pend_rv = 1'b0;
        for (int i = 0; i < 20 && m_fifo.size() < 3; i++) echo_cycles(1);
        check("rst_fill", m_fifo.size(), 3);
        #3 rst_ni = 1'b0;
        #1 check("rst_valid_drop", fetch_entry_valid_o, 1'b0);
        check("rst_req_drop", instr_req_o, 1'b0);
        @(negedge clk_i);
        tick(); tick();
        rst_ni = 1'b1; fetch_valid_i = 1'b0; pend_rv = 1'b0;
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            flush_i          = (($urandom % 16) == 0);
            fetch_valid_i    = (($urandom % 4) != 0);
            fetch_address_i  = {$urandom, $urandom};
            branch_predict_i.valid           = 1'($urandom);
            branch_predict_i.predict_address = {$urandom, $urandom};
            branch_predict_i.predict_taken   = 1'($urandom);
            instr_gnt_i      = (($urandom % 3) != 0);
            instr_rvalid_i   = (m_inflight > 0) && (($urandom % 2) == 0);
            instr_rdata_i    = $urandom;
            fetch_entry_ready_i = (($urandom % 3) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
